// File: rtl/ysyx_25030085_wbu_if.sv
// ysyx_25030085_wbu_if -- handshake and data bundle of the writeback unit.
//   in_*        : result handed over by the EXU (valid/ready handshake)
//   mem_*       : load data returning from memory
//   rf_*        : register-file write port
//   commit_*    : retire pulse, retiring pc and retired-instruction count
//   err         : sticky load-timeout flag
// Modports: master = EXU/memory/testbench side, slave = writeback unit.
interface ysyx_25030085_wbu_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_cnt;
    logic        err;

    modport master (
        output in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result,
               in_pc, in_imm, mem_rvalid, mem_rdata,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid,
               commit_pc, commit_cnt, err
    );

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result,
               in_pc, in_imm, mem_rvalid, mem_rdata,
        output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid,
               commit_pc, commit_cnt, err
    );
endinterface

// File: rtl/ysyx_25030085_wbu.sv
// ysyx_25030085_wbu -- writeback unit.
// Accepts one EXU result at a time, selects the writeback value (ALU, load
// data, pc+4 or immediate), waits for load data when needed, then retires the
// instruction with a one-cycle commit pulse and an optional register write.
// Ports:
//   clk  : clock, all state updates on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : ysyx_25030085_wbu_if.slave (handshake, memory, rf and commit signals)
// Optional feature: define YSYX_25030085_WBU_TIMEOUT_EN to abandon a load after
// 255 cycles without load data and raise the sticky err flag.
module ysyx_25030085_wbu (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_25030085_wbu_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic        wen_q, wen_d;
    logic        cv_q, cv_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
    logic [7:0]  tmo_q, tmo_d;
`endif

    // Writeback value for non-load sources; load data arrives later.
    function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                           input logic [31:0] alu,
                                           input logic [31:0] pc,
                                           input logic [31:0] imm);
        logic [31:0] res;
        case (sel)
            2'b00:   res = alu;
            2'b10:   res = pc + 32'd4;
            2'b11:   res = imm;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.rf_wen       = wen_q;
    assign bus.rf_waddr     = rd_q;
    assign bus.rf_wdata     = wdata_q;
    assign bus.commit_valid = cv_q;
    assign bus.commit_pc    = pc_q;
    assign bus.commit_cnt   = cnt_q;
    assign bus.err          = err_q;

    // Next-state and next-output logic; commit outputs are precomputed so they
    // are already registered during the COMMIT cycle.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        wen_d       = 1'b0;
        cv_d        = 1'b0;
        cnt_d       = cnt_q;
        err_d       = err_q;
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rd_d        = bus.in_rd;
                    reg_write_d = bus.in_reg_write;
                    pc_d        = bus.in_pc;
                    if (bus.in_wb_sel == 2'b01) begin
                        state_d = WAIT_MEM;
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
                        tmo_d   = 8'd0;
`endif
                    end else begin
                        state_d = COMMIT;
                        wdata_d = wb_mux(bus.in_wb_sel, bus.in_alu_result,
                                         bus.in_pc, bus.in_imm);
                        wen_d   = bus.in_reg_write && (bus.in_rd != 5'd0);
                        cv_d    = 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d = COMMIT;
                    wdata_d = bus.mem_rdata;
                    wen_d   = reg_write_q && (rd_q != 5'd0);
                    cv_d    = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end else begin
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
                    // The 255th empty wait cycle abandons the load.
                    if (tmo_q == 8'd254) begin
                        tmo_d   = 8'd255;
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d   = tmo_q + 8'd1;
                        state_d = WAIT_MEM;
                    end
`else
                    state_d = WAIT_MEM;
`endif
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            wdata_q     <= 32'd0;
            pc_q        <= 32'd0;
            wen_q       <= 1'b0;
            cv_q        <= 1'b0;
            cnt_q       <= 32'd0;
            err_q       <= 1'b0;
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
            tmo_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            wen_q       <= wen_d;
            cv_q        <= cv_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_wbu.sv
// Testbench for ysyx_25030085_wbu: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle against
// a transaction-level model of the writeback unit.
module tb_ysyx_25030085_wbu;

    logic clk;
    logic rst;
    ysyx_25030085_wbu_if bus();

    ysyx_25030085_wbu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_occ: an instruction is held by the unit; m_wait: it still needs load
    // data; m_commit: it retires in the current cycle.
    bit          m_occ    = 1'b0;
    bit          m_wait   = 1'b0;
    bit          m_commit = 1'b0;
    logic [4:0]  m_rd     = 5'd0;
    bit          m_rw     = 1'b0;
    logic [31:0] m_pc     = 32'd0;
    logic [31:0] m_data   = 32'd0;
    logic [31:0] m_cnt    = 32'd0;
    bit          m_err    = 1'b0;
    int          m_tmo    = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_occ = 0; m_wait = 0; m_commit = 0; m_cnt = 32'd0; m_err = 0; m_tmo = 0;
            chk("m_rst_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("m_rst_wen", {31'd0, bus.rf_wen}, 32'd0);
            chk("m_rst_cv", {31'd0, bus.commit_valid}, 32'd0);
            chk("m_rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
            chk("m_rst_wdata", bus.rf_wdata, 32'd0);
            chk("m_rst_pc", bus.commit_pc, 32'd0);
            chk("m_rst_cnt", bus.commit_cnt, 32'd0);
            chk("m_rst_err", {31'd0, bus.err}, 32'd0);
        end else begin
            logic exp_commit;
            exp_commit = m_occ && m_commit;
            chk("m_ready", {31'd0, bus.in_ready}, {31'd0, !m_occ});
            chk("m_cv", {31'd0, bus.commit_valid}, {31'd0, exp_commit});
            chk("m_wen", {31'd0, bus.rf_wen}, {31'd0, exp_commit && m_rw && (m_rd != 5'd0)});
            chk("m_cnt", bus.commit_cnt, m_cnt);
            chk("m_err", {31'd0, bus.err}, {31'd0, m_err});
            if (exp_commit) begin
                chk("m_waddr", {27'd0, bus.rf_waddr}, {27'd0, m_rd});
                chk("m_wdata", bus.rf_wdata, m_data);
                chk("m_pc", bus.commit_pc, m_pc);
            end
            // advance the model to the next cycle
            if (exp_commit) begin
                m_occ = 0; m_commit = 0;
            end else if (m_occ && m_wait) begin
                if (bus.mem_rvalid) begin
                    m_data = bus.mem_rdata; m_wait = 0; m_commit = 1; m_cnt = m_cnt + 32'd1;
                end else begin
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
                    m_tmo = m_tmo + 1;
                    if (m_tmo == 255) begin
                        m_occ = 0; m_wait = 0; m_err = 1;
                    end
`endif
                end
            end else if (!m_occ && bus.in_valid) begin
                m_occ = 1; m_rd = bus.in_rd; m_rw = bus.in_reg_write; m_pc = bus.in_pc;
                case (bus.in_wb_sel)
                    2'b00: m_data = bus.in_alu_result;
                    2'b10: m_data = bus.in_pc + 32'd4;
                    2'b11: m_data = bus.in_imm;
                    default: m_data = m_data;
                endcase
                if (bus.in_wb_sel == 2'b01) begin
                    m_wait = 1; m_tmo = 0;
                end else begin
                    m_commit = 1; m_cnt = m_cnt + 32'd1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
        bus.in_valid = 1'b1; bus.in_rd = rd; bus.in_reg_write = rw; bus.in_wb_sel = sel;
        bus.in_alu_result = alu; bus.in_pc = pc; bus.in_imm = imm;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_rd = 5'd0; bus.in_reg_write = 1'b0; bus.in_wb_sel = 2'b00;
        bus.in_alu_result = 32'd0; bus.in_pc = 32'd0; bus.in_imm = 32'd0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (3) cyc();
        rst = 1'b0;
        at_neg();
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_rst_cnt", bus.commit_cnt, 32'd0);

        // ALU op
        issue(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0000_0100, 32'd0);
        at_neg();
        chk("alu_wen", {31'd0, bus.rf_wen}, 32'd1);
        chk("alu_waddr", {27'd0, bus.rf_waddr}, 32'd5);
        chk("alu_wdata", bus.rf_wdata, 32'h1234_5678);
        chk("alu_cnt", bus.commit_cnt, 32'd1);
        chk("alu_ready", {31'd0, bus.in_ready}, 32'd0);
        cyc();

        // load with data three cycles after acceptance
        issue(5'd7, 1'b1, 2'b01, 32'h1111_1111, 32'h0000_0200, 32'd0);
        at_neg(); chk("ld_ready1", {31'd0, bus.in_ready}, 32'd0);
        cyc();
        at_neg(); chk("ld_ready2", {31'd0, bus.in_ready}, 32'd0);
        cyc();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        at_neg();
        chk("ld_ready3", {31'd0, bus.in_ready}, 32'd0);
        chk("ld_wen_early", {31'd0, bus.rf_wen}, 32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        at_neg();
        chk("ld_wen", {31'd0, bus.rf_wen}, 32'd1);
        chk("ld_waddr", {27'd0, bus.rf_waddr}, 32'd7);
        chk("ld_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("ld_ready4", {31'd0, bus.in_ready}, 32'd0);
        chk("ld_cnt", bus.commit_cnt, 32'd2);
        cyc();

        // jal at the top of the address space, then a write to x0
        issue(5'd1, 1'b1, 2'b10, 32'd0, 32'hFFFF_FFFC, 32'd0);
        at_neg();
        chk("jal_wdata", bus.rf_wdata, 32'h0000_0000);
        chk("jal_wen", {31'd0, bus.rf_wen}, 32'd1);
        chk("jal_pc", bus.commit_pc, 32'hFFFF_FFFC);
        cyc();
        issue(5'd0, 1'b1, 2'b00, 32'h0000_CAFE, 32'h0000_0300, 32'd0);
        at_neg();
        chk("x0_wen", {31'd0, bus.rf_wen}, 32'd0);
        chk("x0_cv", {31'd0, bus.commit_valid}, 32'd1);
        chk("x0_cnt", bus.commit_cnt, 32'd4);
        cyc();

        // reset while waiting for load data
        issue(5'd9, 1'b1, 2'b01, 32'd0, 32'h0000_0400, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_1234;
        at_neg();
        chk("rstw_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rstw_wen", {31'd0, bus.rf_wen}, 32'd0);
        chk("rstw_cnt", bus.commit_cnt, 32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        at_neg();
        chk("rstw_wen2", {31'd0, bus.rf_wen}, 32'd0);
        chk("rstw_cv2", {31'd0, bus.commit_valid}, 32'd0);
        chk("rstw_cnt2", bus.commit_cnt, 32'd0);
        cyc();

        // load that never receives data
        issue(5'd6, 1'b1, 2'b01, 32'd0, 32'h0000_0500, 32'd0);
        repeat (255) cyc();
        at_neg();
`ifdef YSYX_25030085_WBU_TIMEOUT_EN
        chk("tmo_err", {31'd0, bus.err}, 32'd1);
        chk("tmo_ready", {31'd0, bus.in_ready}, 32'd1);
`else
        chk("tmo_err", {31'd0, bus.err}, 32'd0);
        chk("tmo_ready", {31'd0, bus.in_ready}, 32'd0);
`endif
        chk("tmo_wen", {31'd0, bus.rf_wen}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // back-to-back LUI then ALU
        bus.in_valid = 1'b1; bus.in_rd = 5'd3; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'b11;
        bus.in_imm = 32'hABCD_E000; bus.in_pc = 32'h0000_0600; bus.in_alu_result = 32'd0;
        cyc();
        bus.in_rd = 5'd4; bus.in_wb_sel = 2'b00; bus.in_alu_result = 32'h0000_0055;
        bus.in_pc = 32'h0000_0604;
        at_neg();
        chk("b2b_cv1", {31'd0, bus.commit_valid}, 32'd1);
        chk("b2b_waddr1", {27'd0, bus.rf_waddr}, 32'd3);
        chk("b2b_wdata1", bus.rf_wdata, 32'hABCD_E000);
        chk("b2b_ready1", {31'd0, bus.in_ready}, 32'd0);
        cyc();
        at_neg();
        chk("b2b_cv_gap", {31'd0, bus.commit_valid}, 32'd0);
        chk("b2b_ready2", {31'd0, bus.in_ready}, 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        at_neg();
        chk("b2b_cv2", {31'd0, bus.commit_valid}, 32'd1);
        chk("b2b_waddr2", {27'd0, bus.rf_waddr}, 32'd4);
        chk("b2b_wdata2", bus.rf_wdata, 32'h0000_0055);
        chk("b2b_cnt", bus.commit_cnt, 32'd2);
        cyc();

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst                = ($urandom_range(0, 299) == 0);
            bus.in_valid       = $urandom_range(0, 1);
            bus.in_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.in_reg_write   = ($urandom_range(0, 3) != 0);
            bus.in_wb_sel      = 2'($urandom);
            bus.in_alu_result  = $urandom;
            bus.in_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.in_imm         = $urandom;
            bus.mem_rvalid     = ($urandom_range(0, 3) == 0);
            bus.mem_rdata      = $urandom;
            cyc();
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.mem_rvalid = 1'b0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
